// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: instruction word, buffer entry, PC step.
// Imported by the fetch interface, the instruction FIFO and fetch_unit.
package fetch_unit_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    word  instr;
    word  pc;
    logic fault;
  } fetch_entry_t;

  localparam word PC_STEP = 32'd4;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect input, imem request/response, decode handshake.
// master = fetch_unit (producer toward decode), slave = surrounding system.
interface fetch_unit_if
  import fetch_unit_pkg::*;
  ();

  logic redirect_valid;
  word  redirect_pc;
  logic imem_req_valid;
  logic imem_req_ready;
  word  imem_req_addr;
  logic imem_rsp_valid;
  word  imem_rsp_data;
  logic imem_rsp_err;
  logic instr_valid;
  logic instr_ready;
  word  instruction;
  word  instr_pc;
  logic instr_fault;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output instr_valid, instruction, instr_pc, instr_fault,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  instr_valid, instruction, instr_pc, instr_fault,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Registered instruction buffer of fetch_entry_t (push/pop/flush, count out).
// Ports: clk, rst_n, push, pop, flush, wdata -> head, count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= wdata;
  end

  assign head  = mem[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers words.
// Ports: clk, rst_n, bus (fetch_unit_if.master: redirect, imem, decode).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word RESET_PC   = 32'h0000_0000,
  parameter int  FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  word           pc_q;
  word           rsp_pc_q;
  logic [CW-1:0] out_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] fifo_cnt;
  fetch_entry_t  head;
  fetch_entry_t  wdata;
  logic          redir;
  word           redir_pc;
  logic          credit;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          head_ok;

  assign redir    = bus.redirect_valid;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

  // Every in-flight request already owns a buffer slot.
  assign credit   = (out_q + fifo_cnt) < DEPTH_C;

  assign bus.imem_req_valid = rst_n && (state_q == RUN)
                              && !redir && credit;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  // Responses to requests issued before a redirect are dropped.
  assign push  = bus.imem_rsp_valid && (drop_q == '0) && !redir;
  assign wdata = '{instr: bus.imem_rsp_data,
                   pc:    rsp_pc_q,
                   fault: bus.imem_rsp_err};

  assign head_ok         = (fifo_cnt != '0) && !redir;
  assign bus.instr_valid = head_ok;
  assign bus.instruction = head_ok ? head.instr : '0;
  assign bus.instr_pc    = head_ok ? head.pc    : '0;
  assign bus.instr_fault = head_ok && head.fault;
  assign pop = head_ok && bus.instr_ready;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (wdata),
    .head  (head),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      redir:                    state_d = RUN;
      (push && bus.imem_rsp_err): state_d = HALT;
      default:                  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_q + CW'(req_fire)
                 - CW'(bus.imem_rsp_valid);
      if (redir) begin
        pc_q     <= redir_pc;
        rsp_pc_q <= redir_pc;
        drop_q   <= out_q - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) pc_q <= pc_q + PC_STEP;
        if (push) rsp_pc_q <= rsp_pc_q + PC_STEP;
        if (bus.imem_rsp_valid && drop_q != '0)
          drop_q <= drop_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: epoch-tagged memory/buffer model
// plus hand-computed delivery expectations.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int  DEPTH = 4;
  localparam word RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { word addr; int epoch; int due; } req_t;
  typedef struct { word pc; word data; logic fault; } ent_t;
  typedef struct { int cyc; word pc; word data; logic fault; } dlv_t;

  req_t infl[$];
  ent_t buff[$];
  dlv_t log_q[$];

  int   checks = 0;
  int   failures = 0;
  word  exp_pc;
  int   epoch = 0;
  int   cyc = 0;
  int   lat = 1;
  bit   halted = 0;
  word  err_addr = 32'hFFFF_FFF0;

  bit   redir = 0;
  word  rpc = '0;
  bit   rq_rdy = 1;
  bit   i_rdy = 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic lit(string name, int idx, word pc, word data,
                     logic fault, int at);
    if (idx >= log_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: delivery %0d missing, got %0d want >%0d",
               name, idx, log_q.size(), idx);
    end else begin
      chk({name, "_pc"}, log_q[idx].pc, pc);
      chk({name, "_instr"}, log_q[idx].data, data);
      chk({name, "_fault"}, 32'(log_q[idx].fault), 32'(fault));
      if (at >= 0) chk({name, "_cyc"}, log_q[idx].cyc, at);
    end
  endtask

  task automatic step();
    bit   pres;
    bit   e_rv;
    bit   e_iv;
    req_t r;
    pres = (infl.size() > 0) && (infl[0].due <= cyc);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rq_rdy;
    bus.instr_ready    = i_rdy;
    bus.imem_rsp_valid = pres;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    if (pres) begin
      bus.imem_rsp_data = ~infl[0].addr;
      bus.imem_rsp_err  = (infl[0].addr == err_addr);
    end
    @(negedge clk);
    e_rv = !halted && !redir && (infl.size() + buff.size() < DEPTH);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", bus.imem_req_addr, exp_pc);
    e_iv = (buff.size() > 0) && !redir;
    chk("instr_valid", 32'(bus.instr_valid), 32'(e_iv));
    if (e_iv) begin
      chk("instr_pc", bus.instr_pc, buff[0].pc);
      chk("instruction", bus.instruction, buff[0].data);
      chk("instr_fault", 32'(bus.instr_fault), 32'(buff[0].fault));
    end else begin
      chk("idle_fault", 32'(bus.instr_fault), 32'd0);
    end
    if (pres) r = infl.pop_front();
    if (redir) begin
      buff.delete();
      epoch++;
      exp_pc = {rpc[31:2], 2'b00};
      halted = 0;
    end else begin
      if (e_iv && i_rdy) begin
        log_q.push_back('{cyc, bus.instr_pc, bus.instruction,
                          bus.instr_fault});
        void'(buff.pop_front());
      end
      if (pres && r.epoch == epoch) begin
        buff.push_back('{r.addr, ~r.addr, r.addr == err_addr});
        if (r.addr == err_addr) halted = 1;
      end
      if (e_rv && rq_rdy) begin
        infl.push_back('{exp_pc, epoch, cyc + lat});
        exp_pc += PC_STEP;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int n;
  int rel;

  initial begin
    bus.redirect_valid = 0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 0;
    bus.instr_ready    = 0;
    exp_pc = RPC;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_fault", 32'(bus.instr_fault), 32'd0);
    rst_n = 1;
    cyc = 0;

    // Streaming, single-cycle memory
    run(10);
    lit("s1_first", 0, 32'h0, 32'hFFFF_FFFF, 0, 2);
    lit("s1_second", 1, 32'h4, 32'hFFFF_FFFB, 0, 3);
    lit("s1_fourth", 3, 32'hC, 32'hFFFF_FFF3, 0, 5);
    chk("s1_count", log_q.size(), 8);

    // Decode stall
    n = log_q.size();
    i_rdy = 0;
    run(5);
    i_rdy = 1;
    run(8);
    lit("s2_resume", n, 32'h20, 32'hFFFF_FFDF, 0, 15);
    lit("s2_next", n + 1, 32'h24, 32'hFFFF_FFDB, 0, 16);

    // Redirect with requests in flight, 3-cycle memory
    lat = 3;
    run(6);
    n = log_q.size();
    redir = 1;
    rpc = 32'h100;
    step();
    redir = 0;
    run(12);
    lit("s3_target", n, 32'h100, 32'hFFFF_FEFF, 0, -1);

    // Redirect colliding with response and decode handshake
    lat = 1;
    run(6);
    n = log_q.size();
    redir = 1;
    rpc = 32'h43;
    step();
    redir = 0;
    run(8);
    lit("s4_target", n, 32'h40, 32'hFFFF_FFBF, 0, -1);

    // Access fault halts fetch until redirect
    err_addr = 32'h8;
    redir = 1;
    rpc = 32'h0;
    step();
    redir = 0;
    n = log_q.size();
    run(10);
    lit("s5_fault", n + 2, 32'h8, 32'hFFFF_FFF7, 1, -1);
    chk("s5_halt_count", log_q.size(), n + 4);
    redir = 1;
    rpc = 32'h200;
    step();
    redir = 0;
    run(6);
    lit("s5_resume", n + 4, 32'h200, 32'hFFFF_FDFF, 0, -1);
    err_addr = 32'hFFFF_FFF0;

    // Asynchronous reset with a full buffer
    i_rdy = 0;
    run(8);
    chk("s6_full_valid", 32'(bus.instr_valid), 32'd1);
    rst_n = 0;
    #1;
    chk("s6_rst_req", 32'(bus.imem_req_valid), 32'd0);
    chk("s6_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("s6_rst_fault", 32'(bus.instr_fault), 32'd0);
    bus.imem_rsp_valid = 0;
    infl.delete();
    buff.delete();
    epoch++;
    halted = 0;
    exp_pc = RPC;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst_n = 1;
    rel = cyc;
    n = log_q.size();
    i_rdy = 1;
    run(8);
    lit("s6_restart", n, RPC, 32'hFFFF_FFFF, 0, rel + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
